// File: rtl/clock_gate_pkg.sv
// +----------------------------------------------------------------------------+
// | clock_gate_pkg                                                              |
// | Shared state encodings and parameter-legality helpers for clock gating.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package clock_gate_pkg;

  localparam int c_state_w = 3;

  typedef logic [c_state_w-1:0] cg_state_t;

  localparam cg_state_t c_st_off  = 3'd0;
  localparam cg_state_t c_st_wake = 3'd1;
  localparam cg_state_t c_st_on   = 3'd2;
  localparam cg_state_t c_st_hold = 3'd3;
  localparam cg_state_t c_st_stop = 3'd4;

  function automatic int cg_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // True when an unsigned field of the given width can represent value.
  function automatic bit cg_cnt_fits(input int width, input int value);
    if (width >= 31) return 1'b1;
    return value < (1 << width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_gate_timer.sv
// +----------------------------------------------------------------------------+
// | clock_gate_timer                                                            |
// | Loadable down-counter that holds at zero and flags when it is there.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module clock_gate_timer #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 dec,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - CNT_WIDTH'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/clock_gate_control.sv
// +----------------------------------------------------------------------------+
// | clock_gate_control                                                          |
// | Wake/hold/drain FSM producing the gate ENABLE and a CLK_READY handshake.    |
// | Optional macro CLOCK_GATE_FORCE_ON_EN adds a FORCE_ON input.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module clock_gate_control
  import clock_gate_pkg::*;
#(
  parameter int WAKE_CYCLES  = 2,
  parameter int IDLE_CYCLES  = 16,
  parameter int STOP_CYCLES  = 1,
  parameter int CNT_WIDTH    = 8,
  parameter int ON_CNT_WIDTH = 16
) (
  input  logic                    CLK_IN,
  input  logic                    RESET_N,
  input  logic                    WAKE_REQ,
  input  logic                    BUSY,
`ifdef CLOCK_GATE_FORCE_ON_EN
  input  logic                    FORCE_ON,
`endif
  output logic                    GATE_ENABLE,
  output logic                    CLK_READY,
  output logic [c_state_w-1:0]    STATE,
  output logic [ON_CNT_WIDTH-1:0] ON_COUNT,
  output logic                    PROTOCOL_ERR
);

  if ((WAKE_CYCLES < 1) || (IDLE_CYCLES < 1) || (STOP_CYCLES < 1)) begin : g_bad_cycles
    $error("clock_gate_control: WAKE/IDLE/STOP_CYCLES must all be >= 1");
  end

  if (!cg_cnt_fits(CNT_WIDTH, cg_max3(WAKE_CYCLES, IDLE_CYCLES, STOP_CYCLES) - 1)) begin : g_bad_cnt_width
    $error("clock_gate_control: CNT_WIDTH too small for the largest timer load");
  end

  localparam logic [CNT_WIDTH-1:0] c_wake_load = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_idle_load = CNT_WIDTH'(IDLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_stop_load = CNT_WIDTH'(STOP_CYCLES - 1);

  cg_state_t             r_state;
  cg_state_t             w_state_nxt;
  logic                  w_wake_req;
  logic                  w_tmr_load;
  logic [CNT_WIDTH-1:0]  w_tmr_value;
  logic                  w_tmr_dec;
  logic                  w_tmr_zero;
  logic                  w_illegal;
  logic                  r_err;
  logic [ON_CNT_WIDTH-1:0] r_on_count;

`ifdef CLOCK_GATE_FORCE_ON_EN
  assign w_wake_req = WAKE_REQ | FORCE_ON;
`else
  assign w_wake_req = WAKE_REQ;
`endif

  clock_gate_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk        (CLK_IN),
    .rst_n      (RESET_N),
    .load       (w_tmr_load),
    .load_value (w_tmr_value),
    .dec        (w_tmr_dec),
    .zero       (w_tmr_zero)
  );

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) r_state <= c_st_off;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_value = '0;
    w_tmr_dec   = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      c_st_off: begin
        if (w_wake_req) begin
          w_state_nxt = c_st_wake;
          w_tmr_load  = 1'b1;
          w_tmr_value = c_wake_load;
        end
      end
      c_st_wake: begin
        if (w_tmr_zero) w_state_nxt = c_st_on;
        else            w_tmr_dec   = 1'b1;
      end
      c_st_on: begin
        if (!w_wake_req && !BUSY) begin
          w_state_nxt = c_st_hold;
          w_tmr_load  = 1'b1;
          w_tmr_value = c_idle_load;
        end
      end
      c_st_hold: begin
        // Renewed activity wins over an expiring holdoff on the same edge.
        if (w_wake_req || BUSY) begin
          w_state_nxt = c_st_on;
        end else if (w_tmr_zero) begin
          w_state_nxt = c_st_stop;
          w_tmr_load  = 1'b1;
          w_tmr_value = c_stop_load;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      c_st_stop: begin
        if (w_tmr_zero) begin
          if (w_wake_req) begin
            w_state_nxt = c_st_wake;
            w_tmr_load  = 1'b1;
            w_tmr_value = c_wake_load;
          end else begin
            w_state_nxt = c_st_off;
          end
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_st_off;
        w_illegal   = 1'b1;
      end
    endcase
  end

  always_comb begin
    GATE_ENABLE = 1'b0;
    CLK_READY   = 1'b0;
    case (r_state)
      c_st_wake, c_st_stop: GATE_ENABLE = 1'b1;
      c_st_on, c_st_hold: begin
        GATE_ENABLE = 1'b1;
        CLK_READY   = 1'b1;
      end
      default: ;
    endcase
  end

  // Busy activity while the domain is (being) stopped means a client misbehaved.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      r_err <= 1'b0;
    end else if (w_illegal || (BUSY && ((r_state == c_st_off) || (r_state == c_st_stop)))) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      r_on_count <= '0;
    end else if (GATE_ENABLE && (r_on_count != '1)) begin
      r_on_count <= r_on_count + ON_CNT_WIDTH'(1);
    end
  end

  assign STATE        = r_state;
  assign ON_COUNT     = r_on_count;
  assign PROTOCOL_ERR = r_err;

endmodule

`default_nettype wire
